// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: M0 (pipeline) has priority, M1 (DMA/loader) gets a
// starvation override. Out-of-range accesses are blocked from the RAM and flagged on err.
module dmem_arbiter #(
   parameter int unsigned              ADDRESS_WIDTH = 32,
   parameter int unsigned              DATA_WIDTH    = 32,
   parameter logic [ADDRESS_WIDTH-1:0] ADDR_LO       = 32'h0,
   parameter logic [ADDRESS_WIDTH-1:0] ADDR_HI       = 32'h1FFFF,
   parameter int unsigned              STARVE_LIMIT  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     m0_req,
   input  logic                     m0_we,
   input  logic [ADDRESS_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0]    m0_wdata,
   output logic                     m0_gnt,
   output logic                     m0_rvalid,
   output logic [DATA_WIDTH-1:0]    m0_rdata,
   input  logic                     m1_req,
   input  logic                     m1_we,
   input  logic [ADDRESS_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0]    m1_wdata,
   output logic                     m1_gnt,
   output logic                     m1_rvalid,
   output logic [DATA_WIDTH-1:0]    m1_rdata,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_a,
   output logic [DATA_WIDTH-1:0]    mem_wd,
   input  logic [DATA_WIDTH-1:0]    mem_rd,
   output logic                     err
);

   localparam logic [3:0] WAIT_MAX = 4'(STARVE_LIMIT);

   logic [3:0]               wait_cnt;
   logic                     m1_starving;
   logic                     granted;
   logic                     sel_we;
   logic [ADDRESS_WIDTH-1:0] sel_addr;
   logic                     lo_ok;
   logic                     in_range;
   logic [DATA_WIDTH-1:0]    rd_data;

   // Grants are gated by rst_n so nothing is accepted while reset is held.
   assign m1_starving = m1_req && (wait_cnt == WAIT_MAX);
   assign m0_gnt      = rst_n && m0_req && !m1_starving;
   assign m1_gnt      = rst_n && m1_req && (!m0_req || m1_starving);
   assign granted     = m0_gnt || m1_gnt;

   assign sel_addr = m1_gnt ? m1_addr : m0_addr;
   assign sel_we   = m1_gnt ? m1_we : m0_we;
   assign mem_a    = sel_addr;
   assign mem_wd   = m1_gnt ? m1_wdata : m0_wdata;

   // A zero lower bound is always met; skip the compare rather than test unsigned >= 0.
   if (ADDR_LO == '0) begin : g_lo_zero
      assign lo_ok = 1'b1;
   end else begin : g_lo_cmp
      assign lo_ok = (sel_addr >= ADDR_LO);
   end

   assign in_range = lo_ok && (sel_addr <= ADDR_HI);
   assign mem_we   = granted && sel_we && in_range;
   assign rd_data  = in_range ? mem_rd : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
         err       <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         m0_rvalid <= m0_gnt && !m0_we;
         m1_rvalid <= m1_gnt && !m1_we;
         if (m0_gnt && !m0_we) begin
            m0_rdata <= rd_data;
         end
         if (m1_gnt && !m1_we) begin
            m1_rdata <= rd_data;
         end
         err <= granted && !in_range;
         if (m1_req && !m1_gnt) begin
            if (wait_cnt != WAIT_MAX) begin
               wait_cnt <= wait_cnt + 4'd1;
            end
         end else begin
            wait_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random two-master traffic
// compared against a behavioural arbitration and memory model.
module tb_dmem_arbiter;

   localparam int unsigned LIMIT = 4;
   localparam longint      LO    = 0;
   localparam longint      HI    = 'h1FFFF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_we;
   logic [31:0] mem_a, mem_wd, mem_rd;
   logic        err;

   // Bench-side RAM: posedge write, combinational read, plus a backdoor for preloading.
   bit [31:0]   ram [0:131071];
   logic        bd_we = 1'b0;
   logic [16:0] bd_a;
   logic [31:0] bd_d;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit [31:0] ref_mem [int unsigned];
   int        m1_wait;
   int        obs_wait;
   bit        exp_rv0, exp_rv1, exp_err;
   bit [31:0] exp_rd0, exp_rd1;
   bit        hold0, hold1;
   bit        obs_g0, obs_g1;
   bit [5:0]  pat0, pat1;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bd_we) ram[bd_a] <= bd_d;
      else if (mem_we) ram[mem_a[16:0]] <= mem_wd;
   end
   assign mem_rd = ram[mem_a[16:0]];

   dmem_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_gnt    (m0_gnt),
      .m0_rvalid (m0_rvalid),
      .m0_rdata  (m0_rdata),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_gnt    (m1_gnt),
      .m1_rvalid (m1_rvalid),
      .m1_rdata  (m1_rdata),
      .mem_we    (mem_we),
      .mem_a     (mem_a),
      .mem_wd    (mem_wd),
      .mem_rd    (mem_rd),
      .err       (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return 32'h0;
   endfunction

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(2, 0))
         0:       return 32'($urandom_range(15, 0));
         1:       return 32'h1FFFC + 32'($urandom_range(3, 0));
         default: return 32'h20000 + 32'($urandom_range(3, 0));
      endcase
   endfunction

   task automatic idle();
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
   endtask

   // One clock of traffic: inputs were driven at a negedge; check combinational outputs,
   // advance the model over the posedge, then check registered outputs at the next negedge.
   task automatic cycle();
      bit          g0, g1, we, inr;
      logic [31:0] a, wd;
      bit [31:0]   d;
      #1;
      g0  = m0_req && !(m1_req && m1_wait == int'(LIMIT));
      g1  = m1_req && !g0;
      a   = g1 ? m1_addr : m0_addr;
      wd  = g1 ? m1_wdata : m0_wdata;
      we  = g1 ? m1_we : (g0 ? m0_we : 1'b0);
      inr = (longint'(a) >= LO) && (longint'(a) <= HI);
      check("m0_gnt", 32'(m0_gnt), 32'(g0));
      check("m1_gnt", 32'(m1_gnt), 32'(g1));
      check("double_gnt", 32'(m0_gnt & m1_gnt), 32'h0);
      check("mem_we", 32'(mem_we), 32'((g0 | g1) & we & inr));
      check("mem_a", mem_a, a);
      check("mem_wd", mem_wd, wd);
      obs_g0 = m0_gnt;
      obs_g1 = m1_gnt;
      if (m1_req && !m1_gnt) obs_wait++;
      else if (m1_gnt) begin
         check("m1_wait_bound", 32'(obs_wait <= int'(LIMIT)), 32'h1);
         obs_wait = 0;
      end else obs_wait = 0;

      m1_wait = (m1_req && !g1) ? ((m1_wait < int'(LIMIT)) ? m1_wait + 1 : m1_wait) : 0;
      exp_rv0 = 1'b0;
      exp_rv1 = 1'b0;
      exp_err = (g0 | g1) & !inr;
      if (g0 | g1) begin
         if (!we) begin
            d = inr ? ref_rd(a) : 32'h0;
            if (g0) begin exp_rv0 = 1'b1; exp_rd0 = d; end
            else    begin exp_rv1 = 1'b1; exp_rd1 = d; end
         end else if (inr) begin
            ref_mem[a] = wd;
         end
      end
      hold0 = m0_req && !g0;
      hold1 = m1_req && !g1;

      @(posedge clk);
      @(negedge clk);
      check("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv0));
      check("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv1));
      check("m0_rdata", m0_rdata, exp_rd0);
      check("m1_rdata", m1_rdata, exp_rd1);
      check("err", 32'(err), 32'(exp_err));
   endtask

   task automatic model_reset();
      m1_wait = 0; obs_wait = 0;
      exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_err = 1'b0;
      exp_rd0 = 32'h0; exp_rd1 = 32'h0;
      hold0 = 1'b0; hold1 = 1'b0;
   endtask

   initial begin
      // Reset with an M0 write pending: nothing may be granted or written.
      rst_n = 1'b0;
      idle();
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hAAAA5555;
      model_reset();
      @(negedge clk);
      bd_we = 1'b1; bd_a = 17'h10000; bd_d = 32'hDEADBEEF;
      ref_mem[32'h10000] = 32'hDEADBEEF;
      @(negedge clk);
      bd_a = 17'h0; bd_d = 32'h55AA55AA;
      ref_mem[32'h0] = 32'h55AA55AA;
      @(negedge clk);
      bd_we = 1'b0;
      check("rst_m0_gnt", 32'(m0_gnt), 32'h0);
      check("rst_m1_gnt", 32'(m1_gnt), 32'h0);
      check("rst_mem_we", 32'(mem_we), 32'h0);
      check("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
      check("rst_m1_rvalid", 32'(m1_rvalid), 32'h0);
      check("rst_rdata", m0_rdata | m1_rdata, 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_no_write", ram[16], 32'h0);
      idle();
      rst_n = 1'b1;
      cycle();

      // M0 single read of preloaded word
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10000;
      cycle();
      check("deadbeef_gnt", 32'(obs_g0), 32'h1);
      check("deadbeef_rdata", m0_rdata, 32'hDEADBEEF);
      check("deadbeef_rvalid", 32'(m0_rvalid), 32'h1);
      idle();
      cycle();
      check("rvalid_one_cycle", 32'(m0_rvalid), 32'h0);
      check("rdata_held", m0_rdata, 32'hDEADBEEF);

      // Read-after-write across masters
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
      cycle();
      idle();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
      cycle();
      check("raw_rdata", m0_rdata, 32'h12345678);
      check("raw_ram", ram[32], 32'h12345678);

      // Out-of-range write then read; 0x20000 aliases RAM word 0 in the bench RAM
      idle();
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20000; m0_wdata = 32'hCAFEF00D;
      cycle();
      check("oor_write_err", 32'(err), 32'h1);
      check("oor_ram_unchanged", ram[0], 32'h55AA55AA);
      m0_we = 1'b0;
      cycle();
      check("oor_read_rvalid", 32'(m0_rvalid), 32'h1);
      check("oor_read_rdata", m0_rdata, 32'h0);
      check("oor_read_err", 32'(err), 32'h1);

      // Starvation override with both masters requesting continuously
      idle();
      cycle();
      m0_req = 1'b1; m0_addr = 32'h1;
      m1_req = 1'b1; m1_addr = 32'h2;
      for (int k = 0; k < 6; k++) begin
         cycle();
         pat0[k] = obs_g0;
         pat1[k] = obs_g1;
      end
      check("starve_m1_pattern", 32'(pat1), 32'h10);
      check("starve_m0_pattern", 32'(pat0), 32'h2F);

      // Random traffic
      idle();
      cycle();
      for (int i = 0; i < 400; i++) begin
         if (!hold0) begin
            m0_req = ($urandom_range(9, 0) < 6);
            m0_we = 1'($urandom_range(1, 0)); m0_addr = rand_addr(); m0_wdata = $urandom;
         end
         if (!hold1) begin
            m1_req = ($urandom_range(9, 0) < 5);
            m1_we = 1'($urandom_range(1, 0)); m1_addr = rand_addr(); m1_wdata = $urandom;
         end
         cycle();
      end

      // Reset asserted while a read result is being presented
      idle();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10000;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h3;
      #1;
      check("midrst_gnt", 32'(m0_gnt), 32'h1);
      @(posedge clk);
      #2;
      check("midrst_pre_rvalid", 32'(m0_rvalid), 32'h1);
      rst_n = 1'b0;
      #1;
      check("midrst_rvalid", 32'(m0_rvalid), 32'h0);
      check("midrst_rdata", m0_rdata, 32'h0);
      check("midrst_err", 32'(err), 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("midrst_no_gnt", 32'(m0_gnt | m1_gnt), 32'h0);
         check("midrst_no_we", 32'(mem_we), 32'h0);
      end
      model_reset();
      rst_n = 1'b1;
      cycle();
      check("post_rst_m0_first", 32'(obs_g0), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32: width of all address buses.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of all data buses.
REQ-003 SHALL have parameter ADDR_LO, default 32'h0: lowest legal word address.
REQ-004 SHALL have parameter ADDR_HI, default 32'h1FFFF: highest legal word address.
REQ-005 SHALL have parameter STARVE_LIMIT, default 4: M1 wait cycles before it overrides M0 priority (range 1..15).
REQ-006 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-007 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports mX_req  in  1  access request from master X (X=0 pipeline, X=1 DMA/loader).
REQ-009 SHALL have ports mX_we  in  1  1 = write, 0 = read.
REQ-010 SHALL have ports mX_addr  in  ADDRESS_WIDTH  word address.
REQ-011 SHALL have ports mX_wdata  in  DATA_WIDTH  write data.
REQ-012 SHALL have ports mX_gnt  out  1  combinational grant; access accepted this cycle.
REQ-013 SHALL have ports mX_rvalid  out  1  registered; read data valid.
REQ-014 SHALL have ports mX_rdata  out  DATA_WIDTH  registered read data.
REQ-015 SHALL have port mem_we  out  1  write enable to data RAM (RAM writes on posedge).
REQ-016 SHALL have port mem_a  out  ADDRESS_WIDTH  RAM address.
REQ-017 SHALL have port mem_wd  out  DATA_WIDTH  RAM write data.
REQ-018 SHALL have port mem_rd  in  DATA_WIDTH  RAM combinational read data for mem_a.
REQ-019 SHALL have port err  out  1  registered one-cycle pulse on an out-of-range granted access.

Function
REQ-020 SHALL grant at most one master per cycle; m0_gnt and m1_gnt never both 1.
REQ-021 SHALL grant M0 when m0_req=1, unless M1 is starving (wait_cnt == STARVE_LIMIT and m1_req=1), in which case M1 is granted.
REQ-022 SHALL grant M1 when m1_req=1 and m0_req=0.
REQ-023 SHALL hold internal 4-bit wait_cnt: +1 each cycle m1_req=1 and m1_gnt=0; cleared when m1_gnt=1 or m1_req=0; saturates at STARVE_LIMIT.
REQ-024 SHALL drive mem_a/mem_wd from the granted master; with no grant, mem_a=m0_addr, mem_wd=m0_wdata, mem_we=0.
REQ-025 SHALL assert mem_we = granted & we & in_range, where in_range = (ADDR_LO <= addr <= ADDR_HI).
REQ-026 SHALL on a granted read in cycle N register mem_rd (0 if out of range) into that master's rdata and assert its rvalid for exactly cycle N+1.
REQ-027 SHALL hold mX_rdata unchanged when no new read completes; rvalid low otherwise.
REQ-028 SHALL on granted write not assert rvalid.
REQ-029 SHALL pulse err in cycle N+1 for any out-of-range access granted in cycle N (read or write); an out-of-range write SHALL NOT reach the RAM.
REQ-030 SHALL give read-after-write ordering: a read granted in cycle N+1 of the address written in cycle N returns the new data.
REQ-031 SHALL hold no request queue; an ungranted master keeps req and operands stable until granted.

Reset
REQ-032 SHALL, while rst_n=0, force mX_gnt=0, mem_we=0, mX_rvalid=0, mX_rdata=0, err=0, wait_cnt=0, independent of clk.
REQ-033 SHALL, on reset asserted mid-access, drop any pending rvalid/err; no RAM write SHALL occur in a cycle with rst_n=0.
REQ-034 SHALL resume arbitration on the first posedge after rst_n rises, with M0 priority.

Verification
REQ-035 SHALL verify: M0 read 0x10000 alone, RAM holds 0xDEADBEEF -> m0_gnt=1 same cycle, m0_rvalid=1 and m0_rdata=0xDEADBEEF next cycle.
REQ-036 SHALL verify: M0 and M1 both request continuously, STARVE_LIMIT=4 -> M0 granted cycles 0-3, M1 granted cycle 4, M0 cycle 5, wait_cnt restarts.
REQ-037 SHALL verify: M1 writes 0x12345678 to 0x00020 cycle N, M0 reads 0x00020 cycle N+1 -> m0_rdata=0x12345678 at N+2.
REQ-038 SHALL verify: M0 writes 0x20000 (above ADDR_HI) -> mem_we=0, err=1 next cycle, RAM unchanged; read of 0x20000 -> rdata=0, rvalid=1, err=1.
REQ-039 SHALL verify: rst_n driven low between grant and rvalid cycle -> rvalid, rdata, err immediately 0; no grant until rst_n high.
REQ-040 SHALL verify: random two-master traffic vs. reference memory model -> no double grant, all read data matches, M1 never waits more than STARVE_LIMIT cycles.
